multicycle_cpu: RTL and testbench



---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/cpu_regfile.sv | 52 +++++
 rtl/multicycle_cpu.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Opcodes, FSM states and instruction field positions shared by
//               the multicycle load/store core and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_LD   = 4'h5,
        OP_ST   = 4'h6,
        OP_BEQ  = 4'h7,
        OP_JMP  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam int C_OP_MSB  = 31;
    localparam int C_OP_LSB  = 28;
    localparam int C_RD_MSB  = 27;
    localparam int C_RD_LSB  = 24;
    localparam int C_RS1_MSB = 23;
    localparam int C_RS1_LSB = 20;
    localparam int C_RS2_MSB = 19;
    localparam int C_RS2_LSB = 16;
    localparam int C_IMM_MSB = 15;
    localparam int C_IMM_LSB = 0;

    // Which register fields an opcode actually reads/writes: {rd, rs1, rs2}.
    // Only these are range-checked against the register count.
    function automatic logic [2:0] reg_use(opcode_e op);
        logic [2:0] use_mask;
        case (op)
            OP_LI:                 use_mask = 3'b100;
            OP_ADD, OP_SUB, OP_AND: use_mask = 3'b111;
            OP_LD:                 use_mask = 3'b110;
            OP_ST, OP_BEQ:         use_mask = 3'b011;
            default:               use_mask = 3'b000;
        endcase
        return use_mask;
    endfunction

    function automatic logic is_defined_op(opcode_e op);
        logic known;
        case (op)
            OP_NOP, OP_LI, OP_ADD, OP_SUB, OP_AND,
            OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_HALT: known = 1'b1;
            default:                               known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module      : cpu_regfile
// Description : NUM_REGS x DATA_WIDTH register file, two combinational read
//               ports, one synchronous write port, r0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            rs1_addr,
    input  logic [3:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    // r0 has no storage; indices outside the file never match a slot.
    logic [DATA_WIDTH-1:0] r_regs [1:NUM_REGS-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_addr == 4'(i)) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == 4'(i)) rs1_data = r_regs[i];
            if (rs2_addr == 4'(i)) rs2_data = r_regs[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_cpu.sv
// ============================================================================
// Module      : multicycle_cpu
// Description : Multicycle load/store core (FETCH/EXEC/MEM/HALT) driving a
//               combinational-read, clocked-write single-port memory.
//               Optional retire counter enabled by CPU_RETIRE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  halted,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           retired
);

    localparam logic [4:0] C_NUM_REGS = 5'(NUM_REGS);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] r_ea;
    logic [DATA_WIDTH-1:0] r_ir;
    logic                  r_halted;
    logic                  r_illegal;

    opcode_e               w_op;
    logic [3:0]            w_rd;
    logic [3:0]            w_rs1;
    logic [3:0]            w_rs2;
    logic [15:0]           w_imm;
    logic [DATA_WIDTH-1:0] w_sext_d;
    logic [ADDR_WIDTH-1:0] w_sext_a;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic [DATA_WIDTH-1:0] w_alu;
    logic [ADDR_WIDTH-1:0] w_ea;
    logic [2:0]            w_use;
    logic                  w_illegal;
    logic                  w_rf_we;
    logic [DATA_WIDTH-1:0] w_rf_wdata;
    logic                  w_ea_load;
    logic                  w_st_mem;
    logic                  w_ld_mem;

    assign w_op     = opcode_e'(r_ir[C_OP_MSB:C_OP_LSB]);
    assign w_rd     = r_ir[C_RD_MSB:C_RD_LSB];
    assign w_rs1    = r_ir[C_RS1_MSB:C_RS1_LSB];
    assign w_rs2    = r_ir[C_RS2_MSB:C_RS2_LSB];
    assign w_imm    = r_ir[C_IMM_MSB:C_IMM_LSB];
    assign w_sext_d = DATA_WIDTH'($signed(w_imm));
    assign w_sext_a = ADDR_WIDTH'($signed(w_imm));
    assign w_pc_inc = r_pc + ADDR_WIDTH'(1);
    assign w_ea     = ADDR_WIDTH'(w_rs1_data + w_sext_d);

    assign w_use     = reg_use(w_op);
    assign w_illegal = !is_defined_op(w_op)
                     || (w_use[2] && ({1'b0, w_rd}  >= C_NUM_REGS))
                     || (w_use[1] && ({1'b0, w_rs1} >= C_NUM_REGS))
                     || (w_use[0] && ({1'b0, w_rs2} >= C_NUM_REGS));

    cpu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (w_rs1),
        .rs2_addr (w_rs2),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data),
        .wr_en    (w_rf_we),
        .wr_addr  (w_rd),
        .wr_data  (w_rf_wdata)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_LI:   w_alu = w_sext_d;
            OP_ADD:  w_alu = w_rs1_data + w_rs2_data;
            OP_SUB:  w_alu = w_rs1_data - w_rs2_data;
            OP_AND:  w_alu = w_rs1_data & w_rs2_data;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_ea      <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == S_FETCH) r_ir <= read_data;
            if (w_ea_load)          r_ea <= w_ea;
            if (r_state == S_EXEC && w_state_next == S_HALT) begin
                r_halted  <= 1'b1;
                r_illegal <= w_illegal;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_rf_we      = 1'b0;
        w_rf_wdata   = w_alu;
        w_ea_load    = 1'b0;
        case (r_state)
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_illegal || w_op == OP_HALT) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_FETCH;
                    case (w_op)
                        OP_LI, OP_ADD, OP_SUB, OP_AND: begin
                            w_rf_we   = 1'b1;
                            w_pc_next = w_pc_inc;
                        end
                        OP_BEQ: w_pc_next = (w_rs1_data == w_rs2_data)
                                          ? w_pc_inc + w_sext_a : w_pc_inc;
                        OP_JMP: w_pc_next = ADDR_WIDTH'(w_imm);
                        OP_LD, OP_ST: begin
                            w_ea_load    = 1'b1;
                            w_pc_next    = w_pc_inc;
                            w_state_next = S_MEM;
                        end
                        default: w_pc_next = w_pc_inc;
                    endcase
                end
            end
            S_MEM: begin
                w_state_next = S_FETCH;
                if (w_op == OP_LD) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = read_data;
                end
            end
            default: w_state_next = S_HALT;
        endcase
    end

    assign w_ld_mem = (r_state == S_MEM) && (w_op == OP_LD);
    assign w_st_mem = (r_state == S_MEM) && (w_op == OP_ST);

    // Gating with rst_n keeps a reset landing on the MEM cycle from storing.
    assign read_address  = w_ld_mem ? r_ea : r_pc;
    assign write_address = w_st_mem ? r_ea : '0;
    assign write_data    = w_st_mem ? w_rs2_data : '0;
    assign write_enable  = rst_n && w_st_mem;
    assign halted        = r_halted;
    assign illegal       = r_illegal;
    assign pc            = r_pc;

`ifdef CPU_RETIRE_COUNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    // Every completed instruction returns to FETCH from EXEC or MEM.
    assign w_retire = ((r_state == S_EXEC) || (r_state == S_MEM))
                    && (w_state_next == S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
// ============================================================================
// Module      : tb_multicycle_cpu
// Description : Self-checking bench; instruction-level reference model expands
//               each instruction into its expected per-cycle bus activity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_cpu;

    localparam int          NR  = 8;
    localparam logic [31:0] RPC = 32'h0;

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] ret;
        logic        we;
        logic        h;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] read_address, read_data, write_address, write_data, pc, retired;
    logic        write_enable, halted, illegal;

    logic [31:0] tbmem [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_reg [16];
    logic [31:0] m_pc, m_ret;
    logic        m_halt, m_ill;
    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          we_cycles;

    always #5 clk = ~clk;

    assign read_data = tbmem[read_address[7:0]];

    multicycle_cpu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_REGS   (NR),
        .RESET_PC   (RPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .halted        (halted),
        .illegal       (illegal),
        .pc            (pc),
        .retired       (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [31:0] exp_ret();
`ifdef CPU_RETIRE_COUNT_EN
        return m_ret;
`else
        return 32'h0;
`endif
    endfunction

    task automatic clear_mem(input bit rnd);
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = rnd ? $urandom : 32'h0;
            tbmem[i] = v;
            m_mem[i] = v;
        end
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        tbmem[a] = v;
        m_mem[a] = v;
    endtask

    task automatic mreg_wr(input logic [3:0] r, input logic [31:0] v);
        if (r != 4'd0) m_reg[r] = v;
    endtask

    // Execute one instruction architecturally, queueing the cycles it occupies.
    task automatic model_step();
        exp_t        e;
        logic [31:0] ins, a, b, sx, ea;
        logic [3:0]  op, rd, rs1, rs2;
        logic [15:0] imm;
        bit          ok;
        e = '{ra: m_pc, wa: 32'h0, wd: 32'h0, pc: m_pc, ret: exp_ret(),
               we: 1'b0, h: m_halt, il: m_ill};
        if (m_halt) begin
            q.push_back(e);
            return;
        end
        ins = m_mem[m_pc[7:0]];
        {op, rd, rs1, rs2, imm} = ins;
        q.push_back(e);
        q.push_back(e);
        a  = m_reg[rs1];
        b  = m_reg[rs2];
        sx = {{16{imm[15]}}, imm};
        case (op)
            4'h0, 4'h8, 4'hF: ok = 1;
            4'h1:             ok = (rd < NR);
            4'h2, 4'h3, 4'h4: ok = (rd < NR) && (rs1 < NR) && (rs2 < NR);
            4'h5:             ok = (rd < NR) && (rs1 < NR);
            4'h6, 4'h7:       ok = (rs1 < NR) && (rs2 < NR);
            default:          ok = 0;
        endcase
        if (op == 4'hF || !ok) begin
            m_halt = 1'b1;
            m_ill  = !ok;
            return;
        end
        case (op)
            4'h1: begin mreg_wr(rd, sx);    m_pc = m_pc + 1; end
            4'h2: begin mreg_wr(rd, a + b); m_pc = m_pc + 1; end
            4'h3: begin mreg_wr(rd, a - b); m_pc = m_pc + 1; end
            4'h4: begin mreg_wr(rd, a & b); m_pc = m_pc + 1; end
            4'h7: m_pc = (a == b) ? m_pc + 1 + sx : m_pc + 1;
            4'h8: m_pc = {16'h0, imm};
            4'h5: begin
                ea   = a + sx;
                m_pc = m_pc + 1;
                e.pc = m_pc;
                e.ra = ea;
                q.push_back(e);
                mreg_wr(rd, m_mem[ea[7:0]]);
            end
            4'h6: begin
                ea   = a + sx;
                m_pc = m_pc + 1;
                e.pc = m_pc;
                e.ra = m_pc;
                e.we = 1'b1;
                e.wa = ea;
                e.wd = b;
                q.push_back(e);
                m_mem[ea[7:0]] = b;
            end
            default: m_pc = m_pc + 1;
        endcase
        m_ret = m_ret + 1;
    endtask

    task automatic run(input int ncyc, input int abort_at);
        exp_t        e;
        logic        dw;
        logic [31:0] wa, wd;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_pc", pc, RPC);
        check("reset_halted", {31'h0, halted}, 32'h0);
        check("reset_illegal", {31'h0, illegal}, 32'h0);
        check("reset_retired", retired, 32'h0);
        check("reset_we", {31'h0, write_enable}, 32'h0);
        for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
        m_pc = RPC; m_ret = 0; m_halt = 0; m_ill = 0;
        q.delete();
        we_cycles = 0;
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < ncyc; c++) begin
            if (q.size() == 0) model_step();
            e = q.pop_front();
            check("read_address", read_address, e.ra);
            check("write_enable", {31'h0, write_enable}, {31'h0, e.we});
            check("write_address", write_address, e.wa);
            check("write_data", write_data, e.wd);
            check("pc", pc, e.pc);
            check("halted", {31'h0, halted}, {31'h0, e.h});
            check("illegal", {31'h0, illegal}, {31'h0, e.il});
            check("retired", retired, e.ret);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("we_gated_by_reset", {31'h0, write_enable}, 32'h0);
            end
            dw = write_enable;
            wa = write_address;
            wd = write_data;
            if (dw) we_cycles++;
            @(posedge clk);
            if (dw) tbmem[wa[7:0]] = wd;
            @(negedge clk);
            #1;
            if (c == abort_at) break;
        end
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 19) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_ins();
        int          k;
        logic [15:0] off;
        k   = $urandom_range(0, 19);
        off = 16'($urandom_range(0, 6) - 3);
        case (k)
            0:             return enc(4'h0, 4'h0, 4'h0, 4'h0, 16'h0);
            1, 2, 18, 19:  return enc(4'h1, rnd_reg(), 4'h0, 4'h0, 16'($urandom));
            3, 4:          return enc(4'h2, rnd_reg(), rnd_reg(), rnd_reg(), 16'h0);
            5:             return enc(4'h3, rnd_reg(), rnd_reg(), rnd_reg(), 16'h0);
            6:             return enc(4'h4, rnd_reg(), rnd_reg(), rnd_reg(), 16'h0);
            7, 8, 9:       return enc(4'h5, rnd_reg(), rnd_reg(), 4'h0, 16'($urandom_range(0, 255)));
            10, 11, 12:    return enc(4'h6, 4'h0, rnd_reg(), rnd_reg(), 16'($urandom_range(32, 255)));
            13, 14:        return enc(4'h7, 4'h0, rnd_reg(), rnd_reg(), off);
            15:            return enc(4'h8, 4'h0, 4'h0, 4'h0, 16'($urandom_range(0, 31)));
            16:            return enc(4'hF, 4'h0, 4'h0, 4'h0, 16'h0);
            default:       return enc(4'($urandom_range(9, 14)), 4'h0, 4'h0, 4'h0, 16'h0);
        endcase
    endfunction

    initial begin
        // Arithmetic sequence ending in HALT: 8 cycles to halt at pc 3.
        clear_mem(0);
        poke(0, enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd5));
        poke(1, enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd3));
        poke(2, enc(4'h2, 4'd3, 4'd1, 4'd2, 16'd0));
        poke(3, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        run(8, -1);
        check("halted_after_8", {31'h0, halted}, 32'h1);
        check("halt_pc", pc, 32'd3);
        check("model_r3", m_reg[3], 32'd8);
`ifdef CPU_RETIRE_COUNT_EN
        check("retired_3", retired, 32'd3);
`endif

        // Store then load back through the same effective address.
        clear_mem(0);
        poke(0, enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0010));
        poke(1, enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h00AB));
        poke(2, enc(4'h6, 4'd0, 4'd1, 4'd2, 16'd2));
        poke(3, enc(4'h5, 4'd4, 4'd1, 4'd0, 16'd2));
        poke(4, enc(4'h6, 4'd0, 4'd0, 4'd4, 16'h0042));
        poke(5, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        run(20, -1);
        check("st_mem_0x12", tbmem[8'h12], 32'hAB);
        check("ld_r4_via_0x42", tbmem[8'h42], 32'hAB);
        check("we_cycle_count", we_cycles, 2);

        // Taken BEQ skips LI r5; r5 stored to prove it stayed zero.
        clear_mem(0);
        poke(8'h50, 32'h1234);
        poke(0, enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd1));
        poke(1, enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd1));
        poke(2, enc(4'h7, 4'd0, 4'd1, 4'd2, 16'd1));
        poke(3, enc(4'h1, 4'd5, 4'd0, 4'd0, 16'd9));
        poke(4, enc(4'h6, 4'd0, 4'd0, 4'd5, 16'h0050));
        poke(5, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        run(16, -1);
        check("beq_skip_r5", tbmem[8'h50], 32'h0);

        // BEQ with offset -1 spins on itself.
        clear_mem(0);
        poke(0, enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd2));
        poke(1, enc(4'h7, 4'd0, 4'd0, 4'd0, 16'hFFFF));
        run(20, -1);
        check("beq_loop_pc", pc, 32'd1);

        // Wrapping subtract and discarded r0 write.
        clear_mem(0);
        poke(8'h61, 32'h5A5A);
        poke(0, enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd1));
        poke(1, enc(4'h3, 4'd1, 4'd0, 4'd2, 16'd0));
        poke(2, enc(4'h1, 4'd0, 4'd0, 4'd0, 16'd7));
        poke(3, enc(4'h6, 4'd0, 4'd0, 4'd1, 16'h0060));
        poke(4, enc(4'h6, 4'd0, 4'd0, 4'd0, 16'h0061));
        poke(5, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        run(20, -1);
        check("sub_wrap", tbmem[8'h60], 32'hFFFF_FFFF);
        check("r0_stays_zero", tbmem[8'h61], 32'h0);

        // Undefined opcode halts with illegal set and nothing stored.
        clear_mem(0);
        poke(0, enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0020));
        poke(1, enc(4'hC, 4'd0, 4'd0, 4'd0, 16'd0));
        poke(2, enc(4'h6, 4'd0, 4'd0, 4'd1, 16'd5));
        run(14, -1);
        check("illegal_flag", {31'h0, illegal}, 32'h1);
        check("illegal_pc", pc, 32'd1);
        check("illegal_no_write", we_cycles, 0);

        // Reset during the MEM cycle of a store, then a clean rerun.
        clear_mem(0);
        poke(8'h30, 32'h5555);
        poke(0, enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h0077));
        poke(1, enc(4'h6, 4'd0, 4'd0, 4'd2, 16'h0030));
        poke(2, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
        run(10, 4);
        check("abort_mem_unchanged", tbmem[8'h30], 32'h5555);
        poke(8'h30, 32'h5555);
        run(10, -1);
        check("rerun_store", tbmem[8'h30], 32'h77);

        // Randomised programs with random data memory.
        for (int p = 0; p < 12; p++) begin
            clear_mem(1);
            for (int i = 0; i < 24; i++) poke(i, rnd_ins());
            poke(24, enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0));
            run(200, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
